// File: rtl/adder_pkg.sv
// Shared types and default sizing for the serial operand adder.
// The overflow helper keeps the signed-overflow rule in one place.
package adder_pkg;

  localparam int DEF_LANES = 4;
  localparam int DEF_BPL   = 8;
  localparam int DEF_DIV   = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ADD   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Overflow when both addend MSBs agree and the result MSB disagrees.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/cla_adder.sv
// W-bit carry-lookahead adder built from 4-bit lookahead groups.
// Operands are zero-padded up to a multiple of four bits internally.
module cla_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  localparam int G  = (W + 3) / 4;
  localparam int WP = G * 4;

  logic [WP-1:0] ap, bp, p, g;
  logic [WP:0]   c;

  always_comb begin
    ap        = '0;
    bp        = '0;
    ap[W-1:0] = a;
    bp[W-1:0] = b;
    p         = ap ^ bp;
    g         = ap & bp;
    c         = '0;
    c[0]      = cin;
    for (int k = 0; k < G; k++) begin
      for (int j = 0; j < 3; j++)
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      // Group carry comes straight from the group generate/propagate terms.
      c[4*k+4] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (&p[4*k +: 4] & c[4*k]);
    end
  end

  assign s    = p[W-1:0] ^ c[W-1:0];
  assign cout = c[W];

endmodule

// File: rtl/serial_operand_adder.sv
// Captures two W-bit operands over LANES serial pins, one bit index per
// DIV-cycle slot, then adds or subtracts them and holds the result until ack.
module serial_operand_adder
  import adder_pkg::*;
#(
  parameter  int LANES = DEF_LANES,
  parameter  int BPL   = DEF_BPL,
  parameter  int DIV   = DEF_DIV,
  localparam int W     = LANES * BPL,
  localparam int SW    = $clog2(BPL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode_sub,
  input  logic             cin,
  input  logic [LANES-1:0] a_ser,
  input  logic [LANES-1:0] b_ser,
  input  logic             ack,
  output logic [SW-1:0]    sel,
  output logic [W-1:0]     sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             finish
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  a_reg, b_reg;
  logic          sub_q, cin_q;
  logic          start_low;
  logic          start_edge;

  logic [W-1:0]  b_eff, add_s;
  logic          c_eff, add_co;

  // start_low records "start was low last cycle"; clearing it in reset means
  // a start held high across reset cannot fire until it drops and rises.
  assign start_edge = start & start_low;

  // Subtraction is A + ~B + 1, so the carry-out is the not-borrow flag.
  assign b_eff = sub_q ? ~b_reg : b_reg;
  assign c_eff = sub_q ? 1'b1 : cin_q;

  cla_adder #(.W(W)) u_adder (
    .a    (a_reg),
    .b    (b_eff),
    .cin  (c_eff),
    .s    (add_s),
    .cout (add_co)
  );

  // NOTE: every register here, including the capture registers, is cleared by
  // reset and updated with non-blocking assignments so all state moves together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sel       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sub_q     <= 1'b0;
      cin_q     <= 1'b0;
      start_low <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
      finish    <= 1'b0;
    end else begin
      start_low <= ~start;
      case (state)
        IDLE: begin
          if (start_edge) begin
            state <= SHIFT;
            busy  <= 1'b1;
            sel   <= '0;
            cnt   <= '0;
            a_reg <= '0;
            b_reg <= '0;
            sub_q <= mode_sub;
            cin_q <= cin;
          end
        end
        SHIFT: begin
          if (cnt == CW'(DIV - 1)) begin
            cnt <= '0;
            for (int l = 0; l < LANES; l++) begin
              a_reg[l*BPL + int'(sel)] <= a_ser[l];
              b_reg[l*BPL + int'(sel)] <= b_ser[l];
            end
            if (sel == SW'(BPL - 1))
              state <= ADD;
            else
              sel <= sel + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ADD: begin
          sum    <= add_s;
          cout   <= add_co;
          ovf    <= signed_ovf(a_reg[W-1], b_eff[W-1], add_s[W-1]);
          state  <= DONE;
          busy   <= 1'b0;
          finish <= 1'b1;
        end
        DONE: begin
          if (ack) begin
            finish <= 1'b0;
            state  <= IDLE;
            sel    <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_operand_adder.md
SERIAL_OPERAND_ADDER -- requirements
Module: serial_operand_adder

Interface
REQ-001 SHALL have parameter LANES, default 4: serial input pins per operand.
REQ-002 SHALL have parameter BPL, default 8: bits captured per lane; BPL >= 2.
REQ-003 SHALL have parameter DIV, default 6: clk cycles per sample slot; DIV >= 1.
REQ-004 SHALL derive W = LANES*BPL (default 32) and SW = $clog2(BPL).
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  level request; rising edge starts a transaction.
REQ-008 mode_sub  in  1  0 = A+B+cin, 1 = A-B; sampled on start edge.
REQ-009 cin  in  1  carry-in for add mode; sampled on start edge.
REQ-010 a_ser  in  LANES  serial A bits, one per lane.
REQ-011 b_ser  in  LANES  serial B bits, one per lane.
REQ-012 ack  in  1  consumer acknowledge of finish.
REQ-013 sel  out  SW  bit index currently requested from the external mux.
REQ-014 sum  out  W  registered result; cout  out  1  carry/not-borrow; ovf  out  1  signed overflow.
REQ-015 busy  out  1  transaction in progress; finish  out  1  result valid.

Function
REQ-016 SHALL detect start edge as start=1 at cycle T with start=0 at T-1 (one internal register).
REQ-017 SHALL implement states IDLE, SHIFT, ADD, DONE; IDLE -> SHIFT on start edge only.
REQ-018 On start edge at T: SHIFT from T+1, busy=1, sel=0, slot counter=0, A/B capture registers cleared, mode_sub/cin latched.
REQ-019 In SHIFT, slot counter SHALL count 0..DIV-1; at count DIV-1, A[l*BPL+sel]<=a_ser[l], B[l*BPL+sel]<=b_ser[l] for all l, then sel increments.
REQ-020 After the sample with sel=BPL-1: sel holds at BPL-1 and state -> ADD (no wrap of sel).
REQ-021 ADD SHALL last one cycle and register sum, cout, ovf from the adder sub-module.
REQ-022 Add mode: {cout,sum}=A+B+cin; sub mode: sum=A+~B+1, cin ignored, cout=1 when A>=B unsigned.
REQ-023 ovf SHALL be signed overflow of the W-bit operation (operand MSBs equal-after-inversion, result MSB differs).
REQ-024 DONE entered at T+DIV*BPL+2 (T+50 at defaults): finish=1, busy=0; sum/cout/ovf stable.
REQ-025 finish SHALL hold until ack=1 in DONE; next cycle finish=0, state IDLE, sel=0; sum/cout/ovf retained.
REQ-026 ack outside DONE SHALL be ignored; ack and start edge together in DONE: ack wins, start edge dropped.
REQ-027 Start edges in SHIFT, ADD, or DONE SHALL be ignored; start held high SHALL not retrigger.
REQ-028 mode_sub/cin/a_ser/b_ser changes outside their sample points SHALL have no effect.

Reset
REQ-029 rst=1 at any clock edge, any state: state IDLE, busy=0, finish=0, sel=0, slot counter=0, sum=0, cout=0, ovf=0, capture registers=0, edge register=0.
REQ-030 After rst release, start held high SHALL not begin a transaction until it goes low then high.

Structure
REQ-031 Package adder_pkg SHALL hold the state enum and DIV/BPL default constants.
REQ-032 One sub-module cla_adder #(W) (A, B, cin -> S, Cout) SHALL perform the addition; the ~B/forced-carry selection lives in the parent.

Verification
REQ-033 Defaults, add, A=0x0000_0001, B=0xFFFF_FFFF, cin=0 -> finish at T+50, sum=0x0000_0000, cout=1, ovf=0.
REQ-034 Sub, A=5, B=7 -> sum=0xFFFF_FFFE, cout=0, ovf=0; then A=7, B=5 -> sum=2, cout=1.
REQ-035 Add, A=0x7FFF_FFFF, B=1, cin=0 -> sum=0x8000_0000, ovf=1; sel walks 0..7, each value for 6 cycles.
REQ-036 rst pulsed with sel=3 mid-SHIFT -> all outputs zero next cycle; fresh start gives correct result.
REQ-037 Second start edge during SHIFT and ack before DONE -> ignored, result and timing unchanged; finish holds 20 cycles until ack, then IDLE.
REQ-038 LANES=2, BPL=4, DIV=1, add, A=0x0F, B=0x01 -> sum=0x10, finish at T+6.
